// File: rtl/alu_pkg.sv
// Shared constants for the integer multiply/divide unit: RV M-extension
// funct3 codes, the opcodes that select the unit, and its FSM encoding.
package alu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OP_OP   = 7'b0110011;
    localparam logic [6:0] OP_OP32 = 7'b0111011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the iterative multiplier/divider.
// Multiply: MSB-first shift-add into a 2W-bit accumulator, the multiplier
// shifts out of opnd from the top.
// Divide: restoring step; the dividend shifts out of opnd into the partial
// remainder (acc low half) while quotient bits shift into opnd from below.
module muldiv_step #(
    parameter int W = 64
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc_in,
    input  logic [W-1:0]   opnd_in,
    input  logic [W-1:0]   mcand,
    output logic [2*W-1:0] acc_out,
    output logic [W-1:0]   opnd_out
);

    logic [W:0] rem_sh;
    logic [W:0] diff;

    // Single combinational iteration, selected by operation class
    always_comb begin
        acc_out  = '0;
        opnd_out = '0;
        rem_sh   = {acc_in[W-1:0], opnd_in[W-1]};
        diff     = rem_sh - {1'b0, mcand};
        if (is_div) begin
            if (!diff[W]) begin
                acc_out  = {{W{1'b0}}, diff[W-1:0]};
                opnd_out = {opnd_in[W-2:0], 1'b1};
            end else begin
                acc_out  = {{W{1'b0}}, rem_sh[W-1:0]};
                opnd_out = {opnd_in[W-2:0], 1'b0};
            end
        end else begin
            acc_out  = (acc_in << 1) + (opnd_in[W-1] ? {{W{1'b0}}, mcand} : {(2*W){1'b0}});
            opnd_out = {opnd_in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV64M multiply/divide unit. Operands are reduced to magnitudes
// at accept, one bit is processed per cycle, and the sign is restored in the
// cycle that enters DONE. Divide-by-zero and signed overflow can bypass the
// iteration entirely when EARLY_OUT is set.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_t            state_q, state_d;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   result_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              word_q;
    logic              neg_q;
    logic              neg_rem_q;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
    logic [XLEN-1:0]   opnd_load, early_raw, early_res;
    logic              b_zero, div_ovf, early, accept;

    logic [2*XLEN-1:0] step_acc, prod_s;
    logic [XLEN-1:0]   step_opnd, quo_s, rem_s, raw_res, final_res;

    // Operand decode at accept: word truncation, sign handling, early-out detection
    always_comb begin
        a_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_ext     = word ? (a_signed ? sext32(a[31:0]) : XLEN'(a[31:0])) : a;
        b_ext     = word ? (b_signed ? sext32(b[31:0]) : XLEN'(b[31:0])) : b;
        sa        = a_signed & a_ext[XLEN-1];
        sb        = b_signed & b_ext[XLEN-1];
        a_mag     = sa ? -a_ext : a_ext;
        b_mag     = sb ? -b_ext : b_ext;
        b_zero    = (b_ext == '0);
        min_val   = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (a_ext == min_val) && (b_ext == '1);
        early     = EARLY_OUT && funct3[2] && (b_zero || div_ovf);
        if (funct3[1]) begin
            early_raw = b_zero ? a_ext : '0;
        end else begin
            early_raw = b_zero ? '1 : a_ext;
        end
        early_res = word ? sext32(early_raw[31:0]) : early_raw;
        opnd_load = word ? (a_mag << (XLEN - 32)) : a_mag;
    end

    muldiv_step #(.W(XLEN)) u_step (
        .is_div   (f3_q[2]),
        .acc_in   (acc_q),
        .opnd_in  (opnd_q),
        .mcand    (mcand_q),
        .acc_out  (step_acc),
        .opnd_out (step_opnd)
    );

    // Final sign restore and result selection from the last iteration's output
    always_comb begin
        prod_s = neg_q ? -step_acc : step_acc;
        quo_s  = neg_q ? -step_opnd : step_opnd;
        rem_s  = neg_rem_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        case (f3_q)
            F3_MUL:                       raw_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: raw_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              raw_res = quo_s;
            default:                      raw_res = rem_s;
        endcase
        final_res = word_q ? sext32(raw_res[31:0]) : raw_res;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; flush overrides everything
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = early ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Datapath: load operands at accept, iterate while busy, capture the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            mcand_q   <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            f3_q      <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            acc_q     <= '0;
            opnd_q    <= opnd_load;
            mcand_q   <= b_mag;
            cnt_q     <= word ? CW'(32) : CW'(XLEN);
            f3_q      <= funct3;
            word_q    <= word;
            neg_q     <= (sa ^ sb) & ~(funct3[2] & b_zero);
            neg_rem_q <= sa;
            if (early) begin
                result_q <= early_res;
            end
        end else if (state_q == BUSY && !flush) begin
            acc_q  <= step_acc;
            opnd_q <= step_opnd;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                result_q <= final_res;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=64, EARLY_OUT=1): directed vector
// table, hand-written control sequences, and random ops against a plain
// arithmetic reference model.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  funct3;
    logic        word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] exp_res;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vq[$];

    alu_muldiv #(.XLEN(64), .EARLY_OUT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .word      (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V M semantics from plain arithmetic
    function automatic logic [63:0] refResult(input logic [63:0] ra, input logic [63:0] rb,
                                              input logic [2:0] f3, input logic w);
        logic [127:0] ae, be, p;
        logic [31:0]  a32, b32, r32;
        int           s32a, s32b;
        longint       s64a, s64b;
        logic [63:0]  r;
        r = '0;
        if (w) begin
            a32 = ra[31:0];
            b32 = rb[31:0];
            s32a = a32;
            s32b = b32;
            r32 = '0;
            case (f3)
                F3_MUL: r32 = a32 * b32;
                F3_DIV: begin
                    if (b32 == 0) r32 = 32'hFFFF_FFFF;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                    else r32 = s32a / s32b;
                end
                F3_DIVU: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
                F3_REM: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 0;
                    else r32 = s32a % s32b;
                end
                F3_REMU: r32 = (b32 == 0) ? a32 : a32 % b32;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            s64a = ra;
            s64b = rb;
            case (f3)
                F3_MUL: r = ra * rb;
                F3_MULH, F3_MULHSU, F3_MULHU: begin
                    ae = (f3 != F3_MULHU) ? {{64{ra[63]}}, ra} : {64'd0, ra};
                    be = (f3 == F3_MULH)  ? {{64{rb[63]}}, rb} : {64'd0, rb};
                    p  = ae * be;
                    r  = p[127:64];
                end
                F3_DIV: begin
                    if (rb == 0) r = '1;
                    else if (ra == 64'h8000_0000_0000_0000 && rb == '1) r = ra;
                    else r = s64a / s64b;
                end
                F3_DIVU: r = (rb == 0) ? '1 : ra / rb;
                F3_REM: begin
                    if (rb == 0) r = ra;
                    else if (ra == 64'h8000_0000_0000_0000 && rb == '1) r = '0;
                    else r = s64a % s64b;
                end
                default: r = (rb == 0) ? ra : ra % rb;
            endcase
        end
        return r;
    endfunction

    // Expected edges from accept to out_valid visible, accept edge counted as 1
    function automatic int refLatency(input logic [63:0] ra, input logic [63:0] rb,
                                      input logic [2:0] f3, input logic w);
        logic bz, ovf;
        bz  = w ? (rb[31:0] == 0) : (rb == 0);
        ovf = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
              (w ? (ra[31:0] == 32'h8000_0000 && rb[31:0] == 32'hFFFF_FFFF)
                 : (ra == 64'h8000_0000_0000_0000 && rb == '1));
        if (f3[2] && (bz || ovf)) return 1;
        return w ? 33 : 65;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait for its result and consume it; inputs change #1 after posedge
    task automatic applyStimulus(input logic [63:0] ta, input logic [63:0] tb_,
                                 input logic [2:0] tf3, input logic tw,
                                 output logic [63:0] res, output int lat);
        int guard;
        a        = ta;
        b        = tb_;
        funct3   = tf3;
        word     = tw;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res       = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res, ra, rb, exp_hold;
        logic [2:0]  rf3;
        logic        rw;
        int          lat, cnt, ov_seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; funct3 = '0; word = 1'b0;

        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        vq.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFD, F3_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_neg"});
        vq.push_back('{'1, '1, F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max"});
        vq.push_back('{'1, 64'd2, F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu"});
        vq.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, F3_MULH, 1'b0, 64'h4000_0000_0000_0000, 65, "mulh_min"});
        vq.push_back('{64'h8000_0000_0000_0000, '1, F3_DIV, 1'b0, 64'h8000_0000_0000_0000, 1, "div_ovf"});
        vq.push_back('{64'h8000_0000_0000_0000, '1, F3_REM, 1'b0, 64'd0, 1, "rem_ovf"});
        vq.push_back('{64'h1234, 64'd0, F3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_zero"});
        vq.push_back('{64'h1234, 64'd0, F3_REMU, 1'b0, 64'h1234, 1, "remu_zero"});
        vq.push_back('{64'hDEAD_0000_FFFF_FFF9, 64'd2, F3_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw"});
        vq.push_back('{64'hDEAD_0000_FFFF_FFF9, 64'd2, F3_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw"});
        vq.push_back('{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_mixed"});
        vq.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 64'd7, F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_negdvd"});
        vq.push_back('{64'h0000_0000_8000_0000, 64'd1, F3_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 33, "divuw_sext"});
        vq.push_back('{64'h0000_0000_7FFF_FFFF, 64'd2, F3_MUL, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_sext"});
        vq.push_back('{64'd5, 64'hFFFF_FFFF_0000_0000, F3_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divw_zero"});
        vq.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, F3_REM, 1'b1, 64'd0, 1, "remw_ovf"});
        vq.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 1, "rem_zero_neg"});

        foreach (vq[i]) begin
            applyStimulus(vq[i].a, vq[i].b, vq[i].f3, vq[i].w, res, lat);
            checkOutput($sformatf("vec%0d_%s_res", i, vq[i].name), res, vq[i].exp_res);
            checkOutput($sformatf("vec%0d_%s_lat", i, vq[i].name), 64'(lat), 64'(vq[i].exp_lat));
        end

        // Flush of an in-flight DIV at the tenth edge after accept
        a = 64'd100; b = 64'd7; funct3 = F3_DIV; word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        ov_seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        checkOutput("flush_no_out_valid", 64'(ov_seen), 64'd0);
        applyStimulus(64'd100, 64'd7, F3_DIV, 1'b0, res, lat);
        checkOutput("after_flush_res", res, 64'd14);
        checkOutput("after_flush_lat", 64'(lat), 64'd65);

        // Flush on the accept edge drops the op
        a = 64'd9; b = 64'd3; funct3 = F3_DIVU; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        ov_seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        checkOutput("flush_accept_dropped", 64'(ov_seen), 64'd0);

        // Back-pressure: hold out_ready low in DONE while a new op is offered
        exp_hold = refResult(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, F3_MUL, 1'b0);
        a = 64'd7; b = 64'hFFFF_FFFF_FFFF_FFFD; funct3 = F3_MUL; word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        a = 64'd1; b = 64'd1; funct3 = F3_DIVU; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("hold%0d_result", k), result, exp_hold);
            checkOutput($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("hold_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("hold_release_in_ready", 64'(in_ready), 64'd1);

        // Throughput with in_valid and out_ready both held high: N+2 edges per op
        a = 64'd100; b = 64'd3; funct3 = F3_DIVU; word = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("throughput_period", 64'(cnt + 1), 64'd66);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (70) @(posedge clk);
        #1 out_ready = 1'b0;

        // Asynchronous reset in the middle of an op
        a = 64'd12345; b = 64'd11; funct3 = F3_REMU; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("async_rst_result", result, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        ov_seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        checkOutput("async_rst_no_out_valid", 64'(ov_seen), 64'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: ra = {$urandom, $urandom};
                1: ra = 64'($urandom_range(0, 50));
                2: ra = -64'($urandom_range(1, 50));
                default: ra = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            endcase
            case ($urandom_range(0, 4))
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(1, 50));
                2: rb = -64'($urandom_range(1, 50));
                3: rb = '1;
                default: rb = 64'd0;
            endcase
            rf3 = 3'($urandom_range(0, 7));
            rw  = ($urandom_range(0, 2) == 0);
            if (rw && (rf3 == F3_MULH || rf3 == F3_MULHSU || rf3 == F3_MULHU)) rw = 1'b0;
            applyStimulus(ra, rb, rf3, rw, res, lat);
            checkOutput($sformatf("rand%0d_f3_%0d_w%0d_res", n, rf3, rw), res, refResult(ra, rb, rf3, rw));
            checkOutput($sformatf("rand%0d_f3_%0d_w%0d_lat", n, rf3, rw), 64'(lat), 64'(refLatency(ra, rb, rf3, rw)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
